// File: rtl/sseg_scan_controller.sv
// Multi-digit seven-segment scan driver: refresh prescaler, digit scan, hex font,
// decimal points, blanking, leading-zero suppression, PWM dimming and anti-ghost gap.
module sseg_scan_controller #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       hex_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic                          lz_blank,
    input  logic [BRIGHT_W-1:0]           brightness,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [6:0]                    seg_n,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_hex;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_mask;

    logic                    slot_end;
    logic                    frame_wrap;
    logic                    pwm_on;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              cur_nibble;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    function automatic logic [6:0] font(input logic [3:0] nibble);
        case (nibble)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    assign slot_end   = en && (prescaler == PRE_LAST);
    assign frame_wrap = slot_end && (digit_idx == IDX_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (slot_end) begin
                prescaler <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
            end else if (en) begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
        end
    end

    // NOTE: the shadow registers are reset because a power-up frame must show
    // defined content; they are small enough that a reset costs nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_hex  <= '0;
            shadow_dp   <= '0;
            shadow_mask <= '0;
        end else if (frame_wrap) begin
            shadow_hex  <= hex_in;
            shadow_dp   <= dp_in;
            shadow_mask <= blank_mask;
        end
    end

    assign pwm_on     = (brightness == '1) || (pwm_cnt < brightness);
    assign cur_nibble = shadow_hex[{digit_idx, 2'b00} +: 4];

    // upper_zero[i]: every shadow nibble from i up to the leftmost digit is zero.
    // NOTE: each always_comb output gets a default first so no latch is inferred.
    always_comb begin
        upper_zero = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i; j < NUM_DIGITS; j++) begin
                if (shadow_hex[4*j +: 4] != 4'h0) begin
                    upper_zero[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        dark = shadow_mask[digit_idx]
            || (lz_blank && (digit_idx != '0) && upper_zero[digit_idx])
            || (prescaler == '0)
            || !pwm_on;
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!dark) begin
            an_d  = ~(NUM_DIGITS'(1) << digit_idx);
            seg_d = font(cur_nibble);
            dp_d  = ~shadow_dp[digit_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= an_d;
            seg_n <= seg_d;
            dp_n  <= dp_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller (4 digits, 4-clock slots, 2-bit brightness).
module tb_sseg_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        lz_blank;
    logic [1:0]  brightness;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    sseg_scan_controller #(
        .NUM_DIGITS (4),
        .REFRESH_DIV(4),
        .BRIGHT_W   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank_mask(blank_mask),
        .lz_blank  (lz_blank),
        .brightness(brightness),
        .an_n      (an_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  mask;
        logic        lz;
        logic [1:0]  br;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dpn;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k     = 0;   // posedges since the last reset release

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic add(input int cyc, input logic [15:0] hex, input logic [3:0] dp,
                       input logic [3:0] mask, input logic lz, input logic [1:0] br,
                       input logic [3:0] an, input logic [6:0] seg, input logic dpn);
        vec_t v;
        v.cyc = cyc; v.hex = hex; v.dp = dp; v.mask = mask; v.lz = lz; v.br = br;
        v.an = an; v.seg = seg; v.dpn = dpn;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lit;
        logic is_lit;

        // Output after edge k reflects internal state after edge k-1; shadow loads at k=16n.
        add(17, 16'hF123, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(18, 16'hF123, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hE, 7'h30, 1'b1);
        add(20, 16'hF123, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hE, 7'h30, 1'b1);
        add(21, 16'hF123, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(22, 16'hF123, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hD, 7'h24, 1'b0);
        add(24, 16'hF123, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hD, 7'h24, 1'b0);
        add(25, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(26, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hB, 7'h79, 1'b1);
        add(28, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hB, 7'h79, 1'b1);
        add(30, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'h7, 7'h0E, 1'b1);
        add(32, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'h7, 7'h0E, 1'b1);
        add(33, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(34, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hE, 7'h40, 1'b1);
        add(38, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hD, 7'h40, 1'b0);
        add(42, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'hB, 7'h40, 1'b1);
        add(46, 16'h0000, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'h7, 7'h40, 1'b1);
        add(47, 16'h0050, 4'b0010, 4'b0000, 1'b0, 2'd3, 4'h7, 7'h40, 1'b1);
        add(49, 16'h0050, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(50, 16'h0050, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hE, 7'h40, 1'b1);
        add(54, 16'h0050, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hD, 7'h12, 1'b0);
        add(58, 16'h0050, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(62, 16'h0050, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(63, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(66, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hE, 7'h40, 1'b1);
        add(70, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(74, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(78, 16'h0000, 4'b0010, 4'b0000, 1'b1, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(79, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd3, 4'h7, 7'h40, 1'b1);
        add(82, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd3, 4'hE, 7'h40, 1'b1);
        add(86, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd3, 4'hD, 7'h40, 1'b0);
        add(90, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(92, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd3, 4'hF, 7'h7F, 1'b1);
        add(94, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd3, 4'h7, 7'h40, 1'b1);
        add(97, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd2, 4'hF, 7'h7F, 1'b1);
        add(98, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd2, 4'hE, 7'h40, 1'b1);
        add(99, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd2, 4'hF, 7'h7F, 1'b1);
        add(100, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd2, 4'hF, 7'h7F, 1'b1);
        add(102, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd2, 4'hD, 7'h40, 1'b0);
        add(103, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd2, 4'hF, 7'h7F, 1'b1);
        add(105, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd0, 4'hF, 7'h7F, 1'b1);
        add(106, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd0, 4'hF, 7'h7F, 1'b1);
        add(110, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd0, 4'hF, 7'h7F, 1'b1);
        add(111, 16'h0000, 4'b0010, 4'b0100, 1'b0, 2'd0, 4'hF, 7'h7F, 1'b1);

        rst_n      = 1'b0;
        en         = 1'b1;
        hex_in     = 16'hF123;
        dp_in      = 4'b0010;
        blank_mask = 4'b0000;
        lz_blank   = 1'b0;
        brightness = 2'd3;

        // Asynchronous reset in the middle of a slot.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        repeat (6) tick();
        check("pre_reset_idx", digit_idx, 2'd1);
        check("pre_reset_an", an_n, 4'hD);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", an_n, 4'hF);
        check("async_rst_seg", seg_n, 7'h7F);
        check("async_rst_dp", dp_n, 1'b1);
        check("async_rst_idx", digit_idx, 2'd0);
        check("async_rst_ft", frame_tick, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        check("idx_after_release", digit_idx, 2'd0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("scan_idx", digit_idx, 32'((c / 4) % 4));
            check("frame_tick", frame_tick, (c == 16) ? 1 : 0);
        end

        // Scan, shadow, leading zeros, mask and brightness table.
        foreach (vecs[i]) begin
            while (k < vecs[i].cyc - 1) tick();
            hex_in     = vecs[i].hex;
            dp_in      = vecs[i].dp;
            blank_mask = vecs[i].mask;
            lz_blank   = vecs[i].lz;
            brightness = vecs[i].br;
            tick();
            check($sformatf("an_n@%0d", vecs[i].cyc), an_n, vecs[i].an);
            check($sformatf("seg_n@%0d", vecs[i].cyc), seg_n, vecs[i].seg);
            check($sformatf("dp_n@%0d", vecs[i].cyc), dp_n, vecs[i].dpn);
        end

        // en low for 20 clocks with prescaler held at 1 on digit 0.
        while (k < 113) tick();
        brightness = 2'd3;
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("hold_idx", digit_idx, 2'd0);
            check("hold_ft", frame_tick, 1'b0);
            check("hold_an", an_n, 4'hE);
        end
        en = 1'b1;
        tick();
        tick();
        check("resume_idx_k135", digit_idx, 2'd0);
        tick();
        check("resume_idx_k136", digit_idx, 2'd1);

        // One more frozen clock shifts the slot phase against the PWM counter.
        en = 1'b0;
        tick();
        en = 1'b1;
        brightness = 2'd1;
        lit = 0;
        for (int c = 0; c < 32; c++) begin
            tick();
            is_lit = (an_n != 4'hF);
            check("pwm1_gate", (is_lit && (((k - 1) % 4) != 0)) ? 1 : 0, 0);
            if (is_lit) lit++;
        end
        check("pwm1_lit_count", lit, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
